// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// state encoding and instruction field positions.
package pacote_controle;

    localparam int unsigned LARGURA_PADRAO  = 16;
    localparam int unsigned BITS_REG_PADRAO = 4;
    localparam int unsigned BITS_OP         = 4;
    localparam int unsigned BITS_ESTADO     = 3;

    localparam int unsigned CAMPO_OPC_MSB = 15;
    localparam int unsigned CAMPO_OPC_LSB = 12;
    localparam int unsigned CAMPO_RC_MSB  = 11;
    localparam int unsigned CAMPO_RC_LSB  = 8;
    localparam int unsigned CAMPO_RA_MSB  = 7;
    localparam int unsigned CAMPO_RA_LSB  = 4;
    localparam int unsigned CAMPO_RB_MSB  = 3;
    localparam int unsigned CAMPO_RB_LSB  = 0;

    localparam logic [BITS_OP-1:0] OPC_ADD  = 4'h0;
    localparam logic [BITS_OP-1:0] OPC_SUB  = 4'h1;
    localparam logic [BITS_OP-1:0] OPC_AND  = 4'h2;
    localparam logic [BITS_OP-1:0] OPC_OR   = 4'h3;
    localparam logic [BITS_OP-1:0] OPC_ADDI = 4'h4;
    localparam logic [BITS_OP-1:0] OPC_SUBI = 4'h5;
    localparam logic [BITS_OP-1:0] OPC_NOP  = 4'hE;
    localparam logic [BITS_OP-1:0] OPC_HALT = 4'hF;

    localparam logic [BITS_OP-1:0] ULA_SOMA = 4'd0;
    localparam logic [BITS_OP-1:0] ULA_SUB  = 4'd1;
    localparam logic [BITS_OP-1:0] ULA_AND  = 4'd2;
    localparam logic [BITS_OP-1:0] ULA_OR   = 4'd3;

    localparam logic [BITS_ESTADO-1:0] OCIOSO  = 3'd0;
    localparam logic [BITS_ESTADO-1:0] LEITURA = 3'd1;
    localparam logic [BITS_ESTADO-1:0] EXECUTA = 3'd2;
    localparam logic [BITS_ESTADO-1:0] ESCRITA = 3'd3;
    localparam logic [BITS_ESTADO-1:0] PARADO  = 3'd4;

    typedef struct packed {
        logic [BITS_OP-1:0] op_ula;
        logic               usa_imediato;
        logic               escreve;
        logic               eh_halt;
        logic               invalido;
    } decod_t;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Combinational opcode decoder: ALU code, immediate select, write-back,
// halt and undefined-opcode flags.
module decodificador_opcode
    import pacote_controle::*;
(
    input  logic [BITS_OP-1:0] opcode,
    output decod_t             decod_c
);

    always_comb begin
        decod_c = '0;
        case (opcode)
            OPC_ADD:  begin decod_c.op_ula = ULA_SOMA; decod_c.escreve = 1'b1; end
            OPC_SUB:  begin decod_c.op_ula = ULA_SUB;  decod_c.escreve = 1'b1; end
            OPC_AND:  begin decod_c.op_ula = ULA_AND;  decod_c.escreve = 1'b1; end
            OPC_OR:   begin decod_c.op_ula = ULA_OR;   decod_c.escreve = 1'b1; end
            OPC_ADDI: begin
                decod_c.op_ula       = ULA_SOMA;
                decod_c.escreve      = 1'b1;
                decod_c.usa_imediato = 1'b1;
            end
            OPC_SUBI: begin
                decod_c.op_ula       = ULA_SUB;
                decod_c.escreve      = 1'b1;
                decod_c.usa_imediato = 1'b1;
            end
            OPC_NOP:  decod_c.op_ula = ULA_SOMA;
            OPC_HALT: decod_c.eh_halt = 1'b1;
            default:  decod_c.invalido = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: OCIOSO -> LEITURA -> EXECUTA -> ESCRITA, driving
// register-bank controls one instruction at a time.
module unidade_controle
    import pacote_controle::*;
#(
    parameter int unsigned LARGURA  = LARGURA_PADRAO,
    parameter int unsigned BITS_REG = BITS_REG_PADRAO
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LARGURA-1:0]  instrucao,
    input  logic                instr_valido,
    output logic                instr_pronto,
    output logic [BITS_REG-1:0] regA,
    output logic [BITS_REG-1:0] regB,
    output logic [BITS_REG-1:0] regC,
    output logic                RW,
    output logic                flagImediato,
    output logic [LARGURA-1:0]  imediato,
    output logic [BITS_OP-1:0]  op_ula,
    output logic                ula_habilita,
    input  logic [LARGURA-1:0]  resultado,
    output logic [LARGURA-1:0]  dado,
    output logic                erro_opcode,
    output logic                parado,
    output logic [LARGURA-1:0]  contador_instr
);

    logic [BITS_ESTADO-1:0] estado_q, estado_d;
    logic [BITS_OP-1:0]     ir_opc_q, ir_opc_d;
    logic [BITS_REG-1:0]    ir_rc_q, ir_rc_d;
    logic [BITS_REG-1:0]    reg_a_q, reg_a_d, reg_b_q, reg_b_d, reg_c_q, reg_c_d;
    logic                   rw_q, rw_d, flag_imm_q, flag_imm_d;
    logic [LARGURA-1:0]     imediato_q, imediato_d, dado_q, dado_d;
    logic [BITS_OP-1:0]     op_ula_q, op_ula_d;
    logic                   ula_hab_q, ula_hab_d, erro_q, erro_d, parado_q, parado_d;
    logic [LARGURA-1:0]     contador_q, contador_d;
    logic [BITS_OP-1:0]     opcode_sel_c;
    decod_t                 decod_c;

    // In OCIOSO decode the incoming word so LEITURA outputs are ready on entry
    assign opcode_sel_c = (estado_q == OCIOSO) ? instrucao[CAMPO_OPC_MSB:CAMPO_OPC_LSB]
                                               : ir_opc_q;

    decodificador_opcode u_decod (
        .opcode  (opcode_sel_c),
        .decod_c (decod_c)
    );

    always_comb begin
        estado_d   = estado_q;
        ir_opc_d   = ir_opc_q;
        ir_rc_d    = ir_rc_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        reg_c_d    = reg_c_q;
        rw_d       = 1'b0;
        flag_imm_d = 1'b0;
        imediato_d = imediato_q;
        op_ula_d   = op_ula_q;
        ula_hab_d  = 1'b0;
        dado_d     = dado_q;
        erro_d     = 1'b0;
        parado_d   = parado_q;
        contador_d = contador_q;
        case (estado_q)
            OCIOSO: begin
                if (instr_valido) begin
                    estado_d   = LEITURA;
                    ir_opc_d   = instrucao[CAMPO_OPC_MSB:CAMPO_OPC_LSB];
                    ir_rc_d    = BITS_REG'(instrucao[CAMPO_RC_MSB:CAMPO_RC_LSB]);
                    reg_a_d    = BITS_REG'(instrucao[CAMPO_RA_MSB:CAMPO_RA_LSB]);
                    reg_b_d    = BITS_REG'(instrucao[CAMPO_RB_MSB:CAMPO_RB_LSB]);
                    flag_imm_d = decod_c.usa_imediato;
                    imediato_d = LARGURA'(instrucao[CAMPO_RA_MSB:CAMPO_RA_LSB]);
                end
            end
            LEITURA: begin
                estado_d  = EXECUTA;
                ula_hab_d = 1'b1;
                op_ula_d  = decod_c.op_ula;
                erro_d    = decod_c.invalido;
            end
            EXECUTA: begin
                if (decod_c.invalido) begin
                    estado_d = OCIOSO;
                end else if (decod_c.eh_halt) begin
                    estado_d   = PARADO;
                    parado_d   = 1'b1;
                    contador_d = contador_q + LARGURA'(1);
                end else if (decod_c.escreve) begin
                    estado_d = ESCRITA;
                    rw_d     = 1'b1;
                    reg_c_d  = ir_rc_q;
                    dado_d   = resultado;
                end else begin
                    estado_d   = OCIOSO;
                    contador_d = contador_q + LARGURA'(1);
                end
            end
            ESCRITA: begin
                estado_d   = OCIOSO;
                contador_d = contador_q + LARGURA'(1);
            end
            PARADO:  estado_d = PARADO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= OCIOSO;
            ir_opc_q   <= '0;
            ir_rc_q    <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            reg_c_q    <= '0;
            rw_q       <= 1'b0;
            flag_imm_q <= 1'b0;
            imediato_q <= '0;
            op_ula_q   <= '0;
            ula_hab_q  <= 1'b0;
            dado_q     <= '0;
            erro_q     <= 1'b0;
            parado_q   <= 1'b0;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            ir_opc_q   <= ir_opc_d;
            ir_rc_q    <= ir_rc_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            reg_c_q    <= reg_c_d;
            rw_q       <= rw_d;
            flag_imm_q <= flag_imm_d;
            imediato_q <= imediato_d;
            op_ula_q   <= op_ula_d;
            ula_hab_q  <= ula_hab_d;
            dado_q     <= dado_d;
            erro_q     <= erro_d;
            parado_q   <= parado_d;
            contador_q <= contador_d;
        end
    end

    assign instr_pronto   = (estado_q == OCIOSO);
    assign regA           = reg_a_q;
    assign regB           = reg_b_q;
    assign regC           = reg_c_q;
    assign RW             = rw_q;
    assign flagImediato   = flag_imm_q;
    assign imediato       = imediato_q;
    assign op_ula         = op_ula_q;
    assign ula_habilita   = ula_hab_q;
    assign dado           = dado_q;
    assign erro_opcode    = erro_q;
    assign parado         = parado_q;
    assign contador_instr = contador_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a small register-bank and ALU model.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instrucao;
    logic        instr_valido;
    logic        instr_pronto;
    logic [3:0]  regA, regB, regC;
    logic        RW, flagImediato;
    logic [15:0] imediato;
    logic [3:0]  op_ula;
    logic        ula_habilita;
    logic [15:0] resultado;
    logic [15:0] dado;
    logic        erro_opcode, parado;
    logic [15:0] contador_instr;

    int passed = 0;
    int total  = 0;

    logic        carga_banco;
    logic [15:0] banco [16];
    logic [15:0] op_a_q, op_b_q;

    always #5 clk = ~clk;

    unidade_controle dut (
        .clk            (clk),
        .rst            (rst),
        .instrucao      (instrucao),
        .instr_valido   (instr_valido),
        .instr_pronto   (instr_pronto),
        .regA           (regA),
        .regB           (regB),
        .regC           (regC),
        .RW             (RW),
        .flagImediato   (flagImediato),
        .imediato       (imediato),
        .op_ula         (op_ula),
        .ula_habilita   (ula_habilita),
        .resultado      (resultado),
        .dado           (dado),
        .erro_opcode    (erro_opcode),
        .parado         (parado),
        .contador_instr (contador_instr)
    );

    // Register bank: registered read ports, write on RW; preload R1=5, R2=3
    always @(posedge clk) begin
        if (carga_banco) begin
            for (int i = 0; i < 16; i++) banco[i] <= 16'h0;
            banco[1] <= 16'd5;
            banco[2] <= 16'd3;
            op_a_q   <= 16'h0;
            op_b_q   <= 16'h0;
        end else if (RW) begin
            banco[regC] <= dado;
        end else begin
            op_a_q <= flagImediato ? {12'h0, regA} : banco[regA];
            op_b_q <= banco[regB];
        end
    end

    always_comb begin
        case (op_ula)
            4'd0:    resultado = op_a_q + op_b_q;
            4'd1:    resultado = op_a_q - op_b_q;
            4'd2:    resultado = op_a_q & op_b_q;
            4'd3:    resultado = op_a_q | op_b_q;
            default: resultado = 16'h0;
        endcase
    end

    task automatic issue(input logic [15:0] w);
        @(negedge clk);
        instrucao    = w;
        instr_valido = 1'b1;
        @(negedge clk);
        instr_valido = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; carga_banco = 1'b1; instr_valido = 1'b0; instrucao = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0; carga_banco = 1'b0;
        total++; if ({regA, regB, regC, op_ula} !== 16'h0) $display("FAIL reset_idx got %h want 0", {regA, regB, regC, op_ula}); else passed++;
        total++; if ({RW, flagImediato, ula_habilita, erro_opcode, parado} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {RW, flagImediato, ula_habilita, erro_opcode, parado}); else passed++;
        total++; if ({imediato, dado, contador_instr} !== 48'h0) $display("FAIL reset_data got %h want 0", {imediato, dado, contador_instr}); else passed++;
        total++; if (instr_pronto !== 1'b1) $display("FAIL reset_pronto got %b want 1", instr_pronto); else passed++;
    endtask

    task automatic test_add;
        issue(16'h0312);
        total++; if ({instr_pronto, RW, regA, regB} !== 10'b00_0001_0010) $display("FAIL add_leitura got %b want 0000010010", {instr_pronto, RW, regA, regB}); else passed++;
        @(negedge clk);
        total++; if ({instr_pronto, ula_habilita, op_ula, RW} !== 7'b0_1_0000_0) $display("FAIL add_executa got %b want 0100000", {instr_pronto, ula_habilita, op_ula, RW}); else passed++;
        @(negedge clk);
        total++; if ({instr_pronto, RW, regC} !== 6'b0_1_0011) $display("FAIL add_escrita_ctl got %b want 010011", {instr_pronto, RW, regC}); else passed++;
        total++; if (dado !== 16'd8) $display("FAIL add_dado got %0d want 8", dado); else passed++;
        @(negedge clk);
        total++; if ({instr_pronto, RW} !== 2'b10) $display("FAIL add_ocioso got %b want 10", {instr_pronto, RW}); else passed++;
        total++; if (contador_instr !== 16'd1) $display("FAIL add_contador got %0d want 1", contador_instr); else passed++;
        total++; if (banco[3] !== 16'd8) $display("FAIL add_r3 got %0d want 8", banco[3]); else passed++;
    endtask

    task automatic test_addi;
        issue(16'h4474);
        total++; if ({flagImediato, regA} !== 5'b1_0111) $display("FAIL addi_flag got %b want 10111", {flagImediato, regA}); else passed++;
        total++; if (imediato !== 16'h0007) $display("FAIL addi_imediato got %h want 0007", imediato); else passed++;
        repeat (2) @(negedge clk);
        total++; if ({RW, regC, dado} !== {1'b1, 4'd4, 16'd7}) $display("FAIL addi_escrita got %h want 14_0007", {RW, regC, dado}); else passed++;
        @(negedge clk);
        total++; if (banco[4] !== 16'd7) $display("FAIL addi_r4 got %0d want 7", banco[4]); else passed++;
        total++; if (contador_instr !== 16'd2) $display("FAIL addi_contador got %0d want 2", contador_instr); else passed++;
    endtask

    task automatic test_invalido;
        issue(16'h9123);
        total++; if ({erro_opcode, RW, instr_pronto} !== 3'b000) $display("FAIL inv_leitura got %b want 000", {erro_opcode, RW, instr_pronto}); else passed++;
        @(negedge clk);
        total++; if ({erro_opcode, RW, instr_pronto} !== 3'b100) $display("FAIL inv_executa got %b want 100", {erro_opcode, RW, instr_pronto}); else passed++;
        @(negedge clk);
        total++; if ({erro_opcode, RW, instr_pronto} !== 3'b001) $display("FAIL inv_ocioso got %b want 001", {erro_opcode, RW, instr_pronto}); else passed++;
        total++; if (contador_instr !== 16'd2) $display("FAIL inv_contador got %0d want 2", contador_instr); else passed++;
    endtask

    task automatic test_reset_meio;
        issue(16'h1512);
        @(negedge clk);
        total++; if ({ula_habilita, op_ula} !== 5'b1_0001) $display("FAIL sub_executa got %b want 10001", {ula_habilita, op_ula}); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({RW, regA, regB, regC, op_ula, ula_habilita, erro_opcode, parado} !== 21'h0) $display("FAIL rstmid_ctl got %h want 0", {RW, regA, regB, regC, op_ula, ula_habilita, erro_opcode, parado}); else passed++;
        total++; if ({dado, imediato, contador_instr} !== 48'h0) $display("FAIL rstmid_data got %h want 0", {dado, imediato, contador_instr}); else passed++;
        total++; if (instr_pronto !== 1'b1) $display("FAIL rstmid_pronto got %b want 1", instr_pronto); else passed++;
        @(negedge clk);
        total++; if (banco[5] !== 16'h0) $display("FAIL rstmid_r5 got %0d want 0", banco[5]); else passed++;
    endtask

    task automatic test_halt;
        issue(16'hF000);
        instrucao    = 16'h0312;
        instr_valido = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({parado, instr_pronto, RW} !== 3'b100) $display("FAIL halt_entra got %b want 100", {parado, instr_pronto, RW}); else passed++;
        total++; if (contador_instr !== 16'd1) $display("FAIL halt_contador got %0d want 1", contador_instr); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if ({parado, instr_pronto, RW} !== 3'b100) $display("FAIL halt_fica%0d got %b want 100", i, {parado, instr_pronto, RW}); else passed++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; instr_valido = 1'b0;
        total++; if ({parado, instr_pronto, contador_instr} !== {2'b01, 16'h0}) $display("FAIL halt_rst got %h want 0_0000 pronto", {parado, instr_pronto, contador_instr}); else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        instrucao    = 16'h0631;
        instr_valido = 1'b1;
        @(negedge clk);
        instrucao = 16'h0766;
        repeat (3) @(negedge clk);
        total++; if (instr_pronto !== 1'b1) $display("FAIL b2b_pronto got %b want 1", instr_pronto); else passed++;
        total++; if (banco[6] !== 16'd13) $display("FAIL b2b_r6 got %0d want 13", banco[6]); else passed++;
        @(negedge clk);
        instr_valido = 1'b0;
        total++; if ({instr_pronto, regA, regB} !== 9'b0_0110_0110) $display("FAIL b2b_leitura got %b want 001100110", {instr_pronto, regA, regB}); else passed++;
        repeat (3) @(negedge clk);
        total++; if (banco[7] !== 16'd26) $display("FAIL b2b_r7 got %0d want 26", banco[7]); else passed++;
        total++; if (contador_instr !== 16'd2) $display("FAIL b2b_contador got %0d want 2", contador_instr); else passed++;
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.contador_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.contador_q;
        @(negedge clk);
        total++; if (contador_instr !== 16'hFFFF) $display("FAIL wrap_carga got %h want ffff", contador_instr); else passed++;
        issue(16'hE000);
        repeat (2) @(negedge clk);
        total++; if ({instr_pronto, contador_instr} !== {1'b1, 16'h0000}) $display("FAIL wrap_zero got %h want 1_0000", {instr_pronto, contador_instr}); else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_invalido();
        test_reset_meio();
        test_halt();
        test_back_to_back();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
